dpd_cacc_round: RTL and testbench

Complex accumulate, round and saturate stage that sits directly downstream of the DPD actuator's complex multiplier. It sums the stream of complex products (basis term × coefficient) for one output sample, rounds the sum, and saturates it to the DAC-path width. It emits one complex output sample per input-sample group and keeps sticky saturation and frame-length error flags for the AXI register map.

---
 rtl/dpd_cacc_round.sv | 148 ++++++++++++++
 tb/tb_dpd_cacc_round.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dpd_cacc_round.sv
// dpd_cacc_round: complex accumulate / round-half-up / saturate stage behind the DPD multiplier.
// Revision 1.0
`default_nettype none

module dpd_cacc_round #(
  parameter int CWIDTH    = 32,
  parameter int AWIDTH    = 40,
  parameter int OWIDTH    = 16,
  parameter int SHIFT     = 14,
  parameter int MAX_TERMS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2*CWIDTH-1:0]   din,
  input  logic                  din_valid,
  input  logic                  din_last,
  output logic [2*OWIDTH-1:0]   dout,
  output logic                  dout_valid,
  input  logic                  stat_clr,
  output logic                  sat_flag,
  output logic                  len_err
);

  localparam int CNTW = $clog2(MAX_TERMS + 1);
  localparam logic [AWIDTH:0] ONE = (AWIDTH+1)'(1);
  localparam logic signed [AWIDTH:0] RND_HALF = signed'(ONE << (SHIFT - 1));
  localparam logic signed [AWIDTH:0] SAT_MAX  = signed'((ONE << (OWIDTH - 1)) - ONE);
  localparam logic signed [AWIDTH:0] SAT_MIN  = signed'(~((ONE << (OWIDTH - 1)) - ONE));

  // ---------------- stage 1: accumulate ----------------
  logic signed [CWIDTH-1:0] din_i, din_q;
  logic signed [AWIDTH-1:0] ext_i, ext_q;
  logic signed [AWIDTH-1:0] acc_i, acc_q;
  logic [CWIDTH*0+CNTW-1:0] term_cnt, term_num;
  logic                     first, close_d, close_cnt, close;

  assign din_i = din[2*CWIDTH-1:CWIDTH];
  assign din_q = din[CWIDTH-1:0];
  assign ext_i = AWIDTH'(din_i);
  assign ext_q = AWIDTH'(din_q);

  // Position of the current term within its sample; the opening term is always number 1.
  assign term_num  = first ? CNTW'(1) : term_cnt + CNTW'(1);
  assign close_cnt = (term_num == CNTW'(MAX_TERMS));
  assign close     = din_last | close_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_i    <= '0;
      acc_q    <= '0;
      term_cnt <= '0;
      first    <= 1'b1;
      close_d  <= 1'b0;
    end else begin
      close_d <= 1'b0;
      if (din_valid) begin
        term_cnt <= term_num;
        acc_i    <= first ? ext_i : acc_i + ext_i;
        acc_q    <= first ? ext_q : acc_q + ext_q;
        first    <= close;
        close_d  <= close;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_err <= 1'b0;
    end else if (din_valid && close_cnt && !din_last) begin
      len_err <= 1'b1;
    end else if (stat_clr) begin
      len_err <= 1'b0;
    end
  end

  // ---------------- stage 2: round half up ----------------
  logic signed [AWIDTH:0] sum_i, sum_q;
  logic signed [AWIDTH:0] rnd_i, rnd_q;
  logic                   v2;

  assign sum_i = (AWIDTH+1)'(acc_i) + RND_HALF;
  assign sum_q = (AWIDTH+1)'(acc_q) + RND_HALF;

  // acc still holds the finished sum here even if stage 1 reloads it on this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      rnd_i <= '0;
      rnd_q <= '0;
    end else begin
      v2 <= close_d;
      if (close_d) begin
        rnd_i <= sum_i >>> SHIFT;
        rnd_q <= sum_q >>> SHIFT;
      end
    end
  end

  // ---------------- stage 3: saturate ----------------
  logic [OWIDTH-1:0] sat_i, sat_q;
  logic              clip_i, clip_q;

  always_comb begin
    sat_i  = rnd_i[OWIDTH-1:0];
    clip_i = 1'b0;
    if (rnd_i > SAT_MAX) begin
      sat_i  = SAT_MAX[OWIDTH-1:0];
      clip_i = 1'b1;
    end else if (rnd_i < SAT_MIN) begin
      sat_i  = SAT_MIN[OWIDTH-1:0];
      clip_i = 1'b1;
    end
  end

  always_comb begin
    sat_q  = rnd_q[OWIDTH-1:0];
    clip_q = 1'b0;
    if (rnd_q > SAT_MAX) begin
      sat_q  = SAT_MAX[OWIDTH-1:0];
      clip_q = 1'b1;
    end else if (rnd_q < SAT_MIN) begin
      sat_q  = SAT_MIN[OWIDTH-1:0];
      clip_q = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      dout_valid <= v2;
      if (v2) begin
        dout <= {sat_i, sat_q};
      end
      // A new saturation event outranks a simultaneous clear.
      if (v2 && (clip_i || clip_q)) begin
        sat_flag <= 1'b1;
      end else if (stat_clr) begin
        sat_flag <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dpd_cacc_round.sv
// tb_dpd_cacc_round: directed checks of dpd_cacc_round with hand-computed expectations.
// Revision 1.0
`default_nettype none

module tb_dpd_cacc_round;

  logic        clk;
  logic        rst_n;
  logic [63:0] din;
  logic        din_valid;
  logic        din_last;
  logic [31:0] dout;
  logic        dout_valid;
  logic        stat_clr;
  logic        sat_flag;
  logic        len_err;

  int cmps = 0;
  int errs = 0;

  dpd_cacc_round dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .dout       (dout),
    .dout_valid (dout_valid),
    .stat_clr   (stat_clr),
    .sat_flag   (sat_flag),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] q, input logic last);
    din_valid = 1'b1;
    din       = {i, q};
    din_last  = last;
    tick();
    din_valid = 1'b0;
    din_last  = 1'b0;
    din       = '0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    din       = '0;
    din_valid = 1'b0;
    din_last  = 1'b0;
    stat_clr  = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_dv", 64'(dout_valid), 64'h0);
    chk("rst_sat", 64'(sat_flag), 64'h0);
    chk("rst_len", 64'(len_err), 64'h0);
    rst_n = 1'b1;
    tick();

    // Single term: 0x4000 -> 1, -0x4000 -> -1; latency exactly 3
    send(32'h0000_4000, 32'hFFFF_C000, 1'b1);
    chk("lat_t1_dv", 64'(dout_valid), 64'h0);
    tick();
    chk("lat_t2_dv", 64'(dout_valid), 64'h0);
    tick();
    chk("lat_t3_dv", 64'(dout_valid), 64'h1);
    chk("lat_t3_dout", 64'(dout), 64'h0001_FFFF);
    tick();
    chk("lat_t4_dv", 64'(dout_valid), 64'h0);
    chk("lat_t4_hold", 64'(dout), 64'h0001_FFFF);
    chk("lat_flags", 64'({sat_flag, len_err}), 64'h0);

    // Round-half-up boundaries, back to back
    send(32'h0000_2000, 32'hFFFF_E000, 1'b1);
    send(32'h0000_1FFF, 32'hFFFF_DFFF, 1'b1);
    tick();
    chk("rnd_a_dv", 64'(dout_valid), 64'h1);
    chk("rnd_a_dout", 64'(dout), 64'h0001_0000);
    tick();
    chk("rnd_b_dv", 64'(dout_valid), 64'h1);
    chk("rnd_b_dout", 64'(dout), 64'h0000_FFFF);
    tick();
    chk("rnd_end_dv", 64'(dout_valid), 64'h0);

    // Saturation: 4 x 2^30 -> +clip, 4 x -2^30 -> -clip
    for (int k = 0; k < 4; k++) send(32'h4000_0000, 32'hC000_0000, (k == 3));
    tick();
    chk("sat_pre_flag", 64'(sat_flag), 64'h0);
    tick();
    chk("sat_dv", 64'(dout_valid), 64'h1);
    chk("sat_dout", 64'(dout), 64'h7FFF_8000);
    chk("sat_flag", 64'(sat_flag), 64'h1);
    tick();

    // Clear coincident with a new saturation: set wins
    for (int k = 0; k < 4; k++) send(32'h4000_0000, 32'hC000_0000, (k == 3));
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("satclr_dv", 64'(dout_valid), 64'h1);
    chk("satclr_flag", 64'(sat_flag), 64'h1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chk("clr_flag", 64'(sat_flag), 64'h0);
    chk("clr_len", 64'(len_err), 64'h0);

    // Three consecutive single-term samples
    send(32'h0000_4000, 32'h0, 1'b1);
    send(32'h0000_8000, 32'h0, 1'b1);
    send(32'h0000_C000, 32'h0, 1'b1);
    chk("b2b_1_dv", 64'(dout_valid), 64'h1);
    chk("b2b_1", 64'(dout), 64'h0001_0000);
    tick();
    chk("b2b_2_dv", 64'(dout_valid), 64'h1);
    chk("b2b_2", 64'(dout), 64'h0002_0000);
    tick();
    chk("b2b_3_dv", 64'(dout_valid), 64'h1);
    chk("b2b_3", 64'(dout), 64'h0003_0000);
    tick();
    chk("b2b_end_dv", 64'(dout_valid), 64'h0);

    // Gaps inside a sample: 3 x (0x4000, -0x4000) -> (3, -3)
    send(32'h0000_4000, 32'hFFFF_C000, 1'b0);
    tick(); tick();
    send(32'h0000_4000, 32'hFFFF_C000, 1'b0);
    tick();
    send(32'h0000_4000, 32'hFFFF_C000, 1'b1);
    tick(); tick();
    chk("gap_dv", 64'(dout_valid), 64'h1);
    chk("gap_dout", 64'(dout), 64'h0003_FFFD);
    tick();

    // 64 terms without last: forced close and len_err
    for (int k = 1; k <= 64; k++) begin
      send(32'h0000_4000, 32'h0, 1'b0);
      if (k < 64) begin
        chk("len_run_dv", 64'(dout_valid), 64'h0);
        chk("len_run_err", 64'(len_err), 64'h0);
      end
    end
    chk("len_err_set", 64'(len_err), 64'h1);
    chk("len_t1_dv", 64'(dout_valid), 64'h0);
    send(32'h0000_8000, 32'h0, 1'b1);
    chk("len_t2_dv", 64'(dout_valid), 64'h0);
    tick();
    chk("len_t3_dv", 64'(dout_valid), 64'h1);
    chk("len_t3_dout", 64'(dout), 64'h0040_0000);
    tick();
    chk("term65_dv", 64'(dout_valid), 64'h1);
    chk("term65_dout", 64'(dout), 64'h0002_0000);
    tick();

    // Reset mid-sample discards the partial sum
    for (int k = 0; k < 3; k++) send(32'h0000_4000, 32'h0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst1_dout", 64'(dout), 64'h0);
    chk("rst1_flags", 64'({sat_flag, len_err}), 64'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst1_dv", 64'(dout_valid), 64'h0);
    end

    // Reset one cycle after a last term drops the in-flight sample
    send(32'h0000_4000, 32'h0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("rst2_dv", 64'(dout_valid), 64'h0);
      tick();
    end

    send(32'h0000_4000, 32'h0, 1'b1);
    tick(); tick();
    chk("post_rst_dv", 64'(dout_valid), 64'h1);
    chk("post_rst_dout", 64'(dout), 64'h0001_0000);
    chk("post_rst_flags", 64'({sat_flag, len_err}), 64'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule

`default_nettype wire
